// File: rtl/dmem_bus_if.sv
// dmem_bus_if: single-outstanding load/store initiator for the external data bus.
// Optional feature: define DMEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without ACKD_n.
module dmem_bus_if #(
    parameter int BIT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 stall,
    output logic [BIT_WIDTH-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 bus_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t               state, state_nxt;
    logic                 signed_q;
    logic                 ddt_oe;
    logic [BIT_WIDTH-1:0] ddt_out;
    logic                 aligned;
    logic                 accept;
    logic                 reject;
    logic                 ack;
    logic                 timeout;

    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_BYTE : sz;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] store_align(input logic [1:0] sz,
                                                         input logic [BIT_WIDTH-1:0] d);
        case (sz)
            SZ_WORD: return d;
            SZ_HALF: return {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] load_extend(input logic [1:0] sz,
                                                         input logic sgn,
                                                         input logic [BIT_WIDTH-1:0] d);
        case (sz)
            SZ_WORD: return d;
            SZ_HALF: return {{(BIT_WIDTH-16){sgn & d[15]}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){sgn & d[7]}}, d[7:0]};
        endcase
    endfunction

    always_comb begin
        case (norm_size(req_size))
            SZ_WORD: aligned = (req_addr[1:0] == 2'b00);
            SZ_HALF: aligned = ~req_addr[0];
            default: aligned = 1'b1;
        endcase
    end

    assign accept = (state == IDLE) & req_valid & aligned;
    assign reject = (state == IDLE) & req_valid & ~aligned;
    assign ack    = (state == BUSY) & ~ACKD_n;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] busy_cnt;

    // busy_cnt holds the number of BUSY cycles already elapsed before the current one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_cnt <= '0;
        else if (accept)
            busy_cnt <= '0;
        else if (state == BUSY)
            busy_cnt <= busy_cnt + 1'b1;
    end

    assign timeout = (state == BUSY) & ACKD_n & (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = BUSY;
                else if (reject)
                    state_nxt = DONE;
            end
            BUSY: begin
                if (ack || timeout)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs and results are registered; the latched request drives the bus for all of BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DAD         <= '0;
            WRITE       <= 1'b0;
            SIZE        <= SZ_WORD;
            signed_q    <= 1'b0;
            ddt_out     <= '0;
            ddt_oe      <= 1'b0;
            MREQ        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            if (accept) begin
                DAD      <= req_addr;
                WRITE    <= req_write;
                SIZE     <= norm_size(req_size);
                signed_q <= req_signed;
                ddt_out  <= store_align(norm_size(req_size), req_wdata);
                ddt_oe   <= req_write;
                MREQ     <= 1'b1;
            end
            if (reject) begin
                rdata       <= '0;
                rdata_valid <= 1'b1;
                bus_err     <= 1'b1;
            end
            if (ack) begin
                MREQ        <= 1'b0;
                ddt_oe      <= 1'b0;
                rdata_valid <= 1'b1;
                if (!WRITE)
                    rdata <= load_extend(SIZE, signed_q, DDT);
            end else if (timeout) begin
                MREQ        <= 1'b0;
                ddt_oe      <= 1'b0;
                rdata       <= '0;
                rdata_valid <= 1'b1;
                bus_err     <= 1'b1;
            end
        end
    end

    assign DDT   = ddt_oe ? ddt_out : 'z;
    assign stall = req_valid & (state != DONE);

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table, reset/timeout sequences,
// and randomized transfers checked against an arithmetic reference model.
module tb_dmem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    wire  [31:0] DDT;
    logic        ACKD_n;

    logic        mem_oe;
    logic [31:0] mem_data;
    assign DDT = mem_oe ? mem_data : 'z;

    int n_assert = 0;
    int n_fail   = 0;
    string cur = "init";
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .bus_err(bus_err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .DDT(DDT), .ACKD_n(ACKD_n)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ddt;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", cur, name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the request fields
    function automatic longint unit_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit is_aligned(input logic [1:0] size, input logic [31:0] addr);
        return (longint'(addr) % unit_bytes(size)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] d);
        longint m, v;
        if (size == 2'd0) return d;
        m = (size == 2'd1) ? 65536 : 256;
        v = longint'(d) % m;
        if (sgn && v >= m / 2) v = v - m;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] d);
        longint m;
        if (size == 2'd0) return d;
        m = (size == 2'd1) ? 65536 : 256;
        return 32'(longint'(d) % m);
    endfunction

    function automatic logic [1:0] model_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mdata, input int waits,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_ddt,
                                input logic exp_err);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.mdata = mdata; v.waits = waits; v.exp_rdata = exp_rdata; v.exp_ddt = exp_ddt;
        v.exp_err = exp_err;
        return v;
    endfunction

    // Called just after a falling edge; returns at the falling edge inside the following IDLE cycle
    task automatic run_xfer(input vec_t v);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        ACKD_n     = 1'b1;
        mem_oe     = !v.wr;
        mem_data   = v.wr ? 32'h0 : v.mdata;
        #1;
        chk("idle_stall", stall, 1);
        chk("idle_mreq", MREQ, 0);
        chk("idle_rvalid", rdata_valid, 0);
        @(negedge clk);
        if (!v.exp_err) begin
            for (int i = 0; i <= v.waits; i++) begin
                chk("busy_mreq", MREQ, 1);
                chk("busy_dad", DAD, v.addr);
                chk("busy_write", WRITE, v.wr);
                chk("busy_size", SIZE, model_size(v.size));
                chk("busy_stall", stall, 1);
                chk("busy_rvalid", rdata_valid, 0);
                if (v.wr) chk("busy_ddt", DDT, v.exp_ddt);
                if (i == v.waits) ACKD_n = 1'b0;
                @(negedge clk);
            end
            ACKD_n = 1'b1;
        end
        mem_oe   = 1'b1;
        mem_data = 32'h0;
        #1;
        chk("done_rvalid", rdata_valid, 1);
        chk("done_err", bus_err, v.exp_err);
        chk("done_stall", stall, 0);
        chk("done_mreq", MREQ, 0);
        chk("done_rdata", rdata, v.exp_rdata);
        chk("done_ddt_z", DDT, 32'h0);
        last_rdata = v.exp_rdata;
        @(negedge clk);
    endtask

    vec_t tbl[11];
    vec_t rv;
    int   busy_cnt;
    bit   seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0, 2'd0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        0);
        tbl[1]  = mk(0, 2'd2, 1, 32'h103, 32'h0,        32'h00000080, 3, 32'hFFFFFF80, 32'h0,        0);
        tbl[2]  = mk(0, 2'd2, 0, 32'h103, 32'h0,        32'h00000080, 3, 32'h00000080, 32'h0,        0);
        tbl[3]  = mk(1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0,        2, 32'h00000080, 32'h0000ABCD, 0);
        tbl[4]  = mk(0, 2'd0, 0, 32'h102, 32'h0,        32'h11111111, 0, 32'h00000000, 32'h0,        1);
        tbl[5]  = mk(0, 2'd1, 1, 32'h206, 32'h0,        32'h1234F00D, 1, 32'hFFFFF00D, 32'h0,        0);
        tbl[6]  = mk(0, 2'd1, 0, 32'h201, 32'h0,        32'h0,        0, 32'h00000000, 32'h0,        1);
        tbl[7]  = mk(1, 2'd2, 0, 32'h305, 32'hAABBCCDD, 32'h0,        0, 32'h00000000, 32'h000000DD, 0);
        tbl[8]  = mk(0, 2'd3, 1, 32'h007, 32'h0,        32'h000000FF, 2, 32'hFFFFFFFF, 32'h0,        0);
        tbl[9]  = mk(1, 2'd0, 0, 32'h400, 32'h87654321, 32'h0,        1, 32'hFFFFFFFF, 32'h87654321, 0);
        tbl[10] = mk(0, 2'd1, 0, 32'h206, 32'h0,        32'h1234F00D, 0, 32'h0000F00D, 32'h0,        0);

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; ACKD_n = 1'b1; mem_oe = 1'b1; mem_data = 32'h0;
        #1;
        cur = "reset";
        chk("mreq", MREQ, 0);
        chk("write", WRITE, 0);
        chk("size", SIZE, 0);
        chk("dad", DAD, 0);
        chk("rdata", rdata, 0);
        chk("rvalid", rdata_valid, 0);
        chk("err", bus_err, 0);
        chk("ddt_z", DDT, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            cur = $sformatf("vec%0d", i);
            run_xfer(tbl[i]);
        end

        // Reset while a store is on the bus
        cur = "reset_mid";
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h500; req_wdata = 32'hCAFEF00D; ACKD_n = 1'b1; mem_oe = 1'b0;
        @(negedge clk);
        chk("busy_mreq", MREQ, 1);
        chk("busy_ddt", DDT, 32'hCAFEF00D);
        rst = 1'b0; mem_oe = 1'b1; mem_data = 32'h0;
        #1;
        chk("mreq", MREQ, 0);
        chk("ddt_z", DDT, 0);
        chk("dad", DAD, 0);
        chk("write", WRITE, 0);
        chk("rdata", rdata, 0);
        chk("rvalid", rdata_valid, 0);
        req_valid = 1'b0; ACKD_n = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_mreq", MREQ, 0);
            chk("post_rvalid", rdata_valid, 0);
            chk("post_stall", stall, 0);
        end
        ACKD_n = 1'b1;
        last_rdata = 32'h0;
        cur = "after_reset";
        run_xfer(tbl[0]);

        // Memory never acknowledges
        cur = "no_ack";
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h400; mem_oe = 1'b1; mem_data = 32'h55AA55AA; ACKD_n = 1'b1;
        @(negedge clk);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rdata_valid) begin
                seen = 1'b1;
                break;
            end
            if (MREQ) busy_cnt++;
            @(negedge clk);
        end
`ifdef DMEM_TIMEOUT_EN
        chk("seen_done", 32'(seen), 1);
        chk("busy_cycles", busy_cnt, 4);
        chk("err", bus_err, 1);
        chk("rdata", rdata, 0);
        chk("mreq", MREQ, 0);
        last_rdata = 32'h0;
        @(negedge clk);
`else
        chk("seen_done", 32'(seen), 0);
        chk("busy_cycles", busy_cnt, 1000);
        chk("mreq", MREQ, 1);
        ACKD_n = 1'b0;
        @(negedge clk);
        ACKD_n = 1'b1;
        chk("late_rvalid", rdata_valid, 1);
        chk("late_err", bus_err, 0);
        chk("late_rdata", rdata, 32'h55AA55AA);
        last_rdata = 32'h55AA55AA;
        @(negedge clk);
`endif

        for (int n = 0; n < 150; n++) begin
            cur = $sformatf("rand%0d", n);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                ACKD_n = $urandom_range(0, 1) ? 1'b0 : 1'b1;
                mem_oe = 1'b1;
                mem_data = $urandom;
                @(negedge clk);
                chk("gap_rvalid", rdata_valid, 0);
                chk("gap_mreq", MREQ, 0);
                chk("gap_rdata_hold", rdata, last_rdata);
                ACKD_n = 1'b1;
            end
            rv.wr    = 1'($urandom_range(0, 1));
            rv.size  = 2'($urandom_range(0, 3));
            rv.sgn   = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.mdata = $urandom;
            rv.waits = $urandom_range(0, 3);
            rv.exp_err   = !is_aligned(rv.size, rv.addr);
            rv.exp_ddt   = model_store(rv.size, rv.wdata);
            rv.exp_rdata = rv.exp_err ? 32'h0 :
                           rv.wr ? last_rdata : model_load(rv.size, rv.sgn, rv.mdata);
            run_xfer(rv);
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
